// File: rtl/calendar_pkg.sv
// Shared state codes, field-select encodings and blink masks for the calendar edit controller.
// Latency: n/a (constants and a helper function only); backpressure: none.
package calendar_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RUN        = 3'd0;
  localparam state_t ST_EDIT_DAY   = 3'd1;
  localparam state_t ST_EDIT_MONTH = 3'd2;
  localparam state_t ST_EDIT_YEAR  = 3'd3;
  localparam state_t ST_EDIT_LOCK  = 3'd4;
  localparam state_t ST_DRAIN      = 3'd5;

  localparam logic [1:0] FLD_DAY   = 2'b00;
  localparam logic [1:0] FLD_MONTH = 2'b01;
  localparam logic [1:0] FLD_YEAR  = 2'b10;
  localparam logic [1:0] FLD_NONE  = 2'b11;

  localparam logic [3:0] BLINK_DAY   = 4'b1100;
  localparam logic [3:0] BLINK_MONTH = 4'b0011;
  localparam logic [3:0] BLINK_YEAR  = 4'b1111;
  localparam logic [3:0] BLINK_OFF   = 4'b0000;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic [2:0] lim);
    return (v >= lim) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold-to-repeat: fires on the press, after HOLD_DLY held cycles, then every RPT_PER.
// Latency: fire_o is combinational in the cycle the condition is met; backpressure: none (clr_i restarts the hold count).
module btn_repeat #(
  parameter logic [15:0] HOLD_DLY = 16'd500,
  parameter logic [15:0] RPT_PER  = 16'd100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic clr_i,
  output logic rise_o,
  output logic fire_o
);

  logic        prev_q;
  logic [15:0] cnt_q, cnt_d, cnt_now;
  logic        rpt_q, rpt_d;
  logic        rpt_fire;

  assign rise_o = btn_i & ~prev_q;

  // cnt_now is the held-cycle count including this cycle; rpt_q selects the first-delay or period threshold.
  always_comb begin
    cnt_now  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    cnt_d    = cnt_now;
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    if (!btn_i || clr_i) begin
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (cnt_now == (rpt_q ? RPT_PER : HOLD_DLY)) begin
      rpt_fire = 1'b1;
      cnt_d    = '0;
      rpt_d    = 1'b1;
    end
  end

  assign fire_o = rise_o | rpt_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      rpt_q  <= 1'b0;
    end else begin
      prev_q <= btn_i;
      cnt_q  <= cnt_d;
      rpt_q  <= rpt_d;
    end
  end

endmodule

// File: rtl/calendar_edit_ctrl.sv
// Run/edit sequencer for the calendar counters: field increment strobes, edit-field select/blink, deferred day ticks.
// Latency: inc strobes one cycle after the press/repeat, adv_day same cycle in RUN; backpressure: none, ticks held in a saturating pending count.
module calendar_edit_ctrl
  import calendar_pkg::*;
#(
  parameter logic [15:0] HOLD_DLY = 16'd500,
  parameter logic [15:0] RPT_PER  = 16'd100,
  parameter logic [23:0] TIMEOUT  = 24'd5000,
  parameter logic [2:0]  PEND_MAX = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit_en,
  input  logic       field_btn,
  input  logic       inc_btn,
  input  logic       new_day,
  output logic       inc_day,
  output logic       inc_month,
  output logic       inc_year,
  output logic       adv_day,
  output logic [1:0] field_sel,
  output logic [3:0] blink,
  output logic       show_year,
  output logic       editing
);

  state_t      state_q, state_d;
  logic        fld_prev_q;
  logic        show_q, show_d;
  logic [2:0]  pend_q, pend_d;
  logic [23:0] idle_q, idle_d;
  logic        inc_day_q, inc_day_d, inc_month_q, inc_month_d, inc_year_q, inc_year_d;
  logic        in_field, fld_rise, inc_rise, inc_fire, adv;

  assign in_field = (state_q == ST_EDIT_DAY) || (state_q == ST_EDIT_MONTH) || (state_q == ST_EDIT_YEAR);
  assign fld_rise = field_btn & ~fld_prev_q;

  btn_repeat #(.HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER)) u_inc_rpt (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (inc_btn),
    .clr_i  (~in_field | fld_rise),
    .rise_o (inc_rise),
    .fire_o (inc_fire)
  );

  always_comb begin
    state_d     = state_q;
    show_d      = show_q;
    pend_d      = pend_q;
    idle_d      = '0;
    adv         = 1'b0;
    inc_day_d   = 1'b0;
    inc_month_d = 1'b0;
    inc_year_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        adv = new_day;
        if (inc_rise) show_d = ~show_q;
        if (edit_en) state_d = ST_EDIT_DAY;
      end
      ST_EDIT_DAY, ST_EDIT_MONTH, ST_EDIT_YEAR: begin
        if (new_day) pend_d = sat_inc3(pend_q, PEND_MAX);
        if (!(fld_rise || inc_fire)) idle_d = (idle_q == 24'hFFFFFF) ? idle_q : idle_q + 24'd1;
        // A strobe is only registered when we stay on this field, so it never lands in DRAIN next to adv_day.
        if (!edit_en) state_d = ST_DRAIN;
        else if (idle_d >= TIMEOUT) state_d = ST_EDIT_LOCK;
        else if (fld_rise) begin
          state_d = (state_q == ST_EDIT_DAY)   ? ST_EDIT_MONTH :
                    (state_q == ST_EDIT_MONTH) ? ST_EDIT_YEAR  : ST_EDIT_DAY;
        end else if (inc_fire) begin
          inc_day_d   = (state_q == ST_EDIT_DAY);
          inc_month_d = (state_q == ST_EDIT_MONTH);
          inc_year_d  = (state_q == ST_EDIT_YEAR);
        end
      end
      ST_EDIT_LOCK: begin
        if (new_day) pend_d = sat_inc3(pend_q, PEND_MAX);
        if (!edit_en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        adv = (pend_q != 3'd0) && !edit_en;
        if (new_day && !adv) pend_d = sat_inc3(pend_q, PEND_MAX);
        else if (adv && !new_day) pend_d = pend_q - 3'd1;
        if (edit_en) state_d = ST_EDIT_DAY;
        else if (pend_d == 3'd0) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    field_sel = FLD_NONE;
    blink     = BLINK_OFF;
    show_year = 1'b0;
    case (state_q)
      ST_EDIT_DAY:   begin field_sel = FLD_DAY;   blink = BLINK_DAY;   end
      ST_EDIT_MONTH: begin field_sel = FLD_MONTH; blink = BLINK_MONTH; end
      ST_EDIT_YEAR:  begin field_sel = FLD_YEAR;  blink = BLINK_YEAR;  show_year = 1'b1; end
      ST_EDIT_LOCK:  show_year = 1'b0;
      default:       show_year = show_q;
    endcase
  end

  assign editing   = in_field || (state_q == ST_EDIT_LOCK);
  assign adv_day   = adv;
  assign inc_day   = inc_day_q;
  assign inc_month = inc_month_q;
  assign inc_year  = inc_year_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fld_prev_q  <= 1'b0;
      show_q      <= 1'b0;
      pend_q      <= '0;
      idle_q      <= '0;
      inc_day_q   <= 1'b0;
      inc_month_q <= 1'b0;
      inc_year_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fld_prev_q  <= field_btn;
      show_q      <= show_d;
      pend_q      <= pend_d;
      idle_q      <= idle_d;
      inc_day_q   <= inc_day_d;
      inc_month_q <= inc_month_d;
      inc_year_q  <= inc_year_d;
    end
  end

endmodule

// File: tb/tb_calendar_edit_ctrl.sv
// Scoreboard bench for calendar_edit_ctrl: a mode-level reference model queues expected strobes and display state.
// Latency: model mirrors press-to-strobe of one cycle; backpressure: none.
module tb_calendar_edit_ctrl;

  localparam int HD = 10;
  localparam int RP = 4;
  localparam int TO = 50;
  localparam int PM = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       edit_en = 1'b0, field_btn = 1'b0, inc_btn = 1'b0, new_day = 1'b0;
  logic       inc_day, inc_month, inc_year, adv_day, show_year, editing;
  logic [1:0] field_sel;
  logic [3:0] blink;

  calendar_edit_ctrl #(
    .HOLD_DLY(16'd10), .RPT_PER(16'd4), .TIMEOUT(24'd50), .PEND_MAX(3'd7)
  ) dut (
    .clk(clk), .rst(rst), .edit_en(edit_en), .field_btn(field_btn), .inc_btn(inc_btn),
    .new_day(new_day), .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year),
    .adv_day(adv_day), .field_sel(field_sel), .blink(blink), .show_year(show_year),
    .editing(editing)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int kind; } ev_t;   // kind: 0 day, 1 month, 2 year, 3 adv
  typedef struct { int cyc; logic [7:0] disp; } st_t;
  typedef enum int { M_RUN, M_EDIT, M_LOCK, M_DRAIN } mode_e;

  ev_t   evq[$];
  st_t   stq[$];
  int    errors = 0, checks = 0, cyc = 0;
  int    n_kind[4];

  mode_e m = M_RUN;
  int    fld = 0, pend = 0, idle = 0, h = 0;
  bit    showy = 0, pf = 0, pi = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one call per cycle, inputs as driven in that cycle.
  task automatic model_step(input bit e, input bit f, input bit i, input bit n);
    bit  fr, ir, rpt, fire, adv;
    int  hn;
    st_t s;
    fr = f && !pf;
    ir = i && !pi;
    cyc++;
    s.cyc = cyc;
    if (m == M_EDIT)
      s.disp = {2'(fld), (fld == 0) ? 4'b1100 : (fld == 1) ? 4'b0011 : 4'b1111, fld == 2, 1'b1};
    else
      s.disp = {2'b11, 4'b0000, (m == M_LOCK) ? 1'b0 : showy, m == M_LOCK};
    stq.push_back(s);
    adv = 0;
    case (m)
      M_RUN: begin
        adv = n;
        if (ir) showy = !showy;
        if (e) begin m = M_EDIT; fld = 0; idle = 0; end
        h = 0;
      end
      M_EDIT: begin
        hn   = i ? h + 1 : 0;
        rpt  = (hn >= HD) && (((hn - HD) % RP) == 0);
        fire = ir || rpt;
        h    = (fr || !i) ? 0 : hn;
        if (n && pend < PM) pend++;
        idle = (fr || fire) ? 0 : idle + 1;
        if (!e) m = M_DRAIN;
        else if (idle >= TO) m = M_LOCK;
        else if (fr) fld = (fld + 1) % 3;
        else if (fire) evq.push_back('{cyc + 1, fld});
      end
      M_LOCK: begin
        if (n && pend < PM) pend++;
        if (!e) m = M_DRAIN;
        h = 0;
      end
      default: begin
        adv = (pend > 0) && !e;
        if (adv && !n) pend--;
        else if (n && !adv && pend < PM) pend++;
        if (e) begin m = M_EDIT; fld = 0; idle = 0; end
        else if (pend == 0) m = M_RUN;
        h = 0;
      end
    endcase
    if (adv) evq.push_back('{cyc, 3});
    pf = f;
    pi = i;
  endtask

  task automatic step(input bit e, input bit f, input bit i, input bit n);
    @(posedge clk);
    #1;
    edit_en = e; field_btn = f; inc_btn = i; new_day = n;
    model_step(e, f, i, n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; edit_en = 0; field_btn = 0; inc_btn = 0; new_day = 0;
    #1;
    chk("rst_field_sel", field_sel, 3);
    chk("rst_blink", blink, 0);
    chk("rst_show_year", show_year, 0);
    chk("rst_editing", editing, 0);
    chk("rst_strobes", {inc_day, inc_month, inc_year, adv_day}, 0);
    evq.delete();
    m = M_RUN; fld = 0; pend = 0; idle = 0; h = 0; showy = 0; pf = 0; pi = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: display state every modelled cycle, strobe events whenever the DUT raises one.
  st_t ms;
  ev_t me;
  int  nstb, kind;
  always @(negedge clk) begin
    if (stq.size() > 0) begin
      ms = stq.pop_front();
      chk("display", {field_sel, blink, show_year, editing}, ms.disp);
    end
    nstb = int'(inc_day) + int'(inc_month) + int'(inc_year) + int'(adv_day);
    checks++;
    if (nstb > 1) begin
      errors++;
      $display("FAIL strobe_exclusive at cycle %0d: got %0d strobes expected at most 1", cyc, nstb);
    end
    if (nstb > 0) begin
      kind = inc_day ? 0 : inc_month ? 1 : inc_year ? 2 : 3;
      n_kind[kind]++;
      checks++;
      if (evq.size() == 0 || evq[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_strobe at cycle %0d: got kind %0d expected none", cyc, kind);
      end else begin
        me = evq.pop_front();
        if (me.kind != kind) begin
          errors++;
          $display("FAIL strobe_kind at cycle %0d: got %0d expected %0d", cyc, kind, me.kind);
        end
      end
    end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
      me = evq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_strobe at cycle %0d: got none expected kind %0d", cyc, me.kind);
    end
  end

  int snap;
  bit re, rf, ri, rn;
  initial begin
    do_reset();

    // Field rotation day -> month -> year -> day.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    end
    chk("rot_back_to_day", field_sel, 0);

    // Auto-repeat: 30 held cycles -> press strobe plus 6 repeats.
    snap = n_kind[0];
    for (int k = 0; k < 30; k++) step(1, 0, 1, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("repeat_count", n_kind[0] - snap, 7);

    // Nine deferred ticks saturate at seven, drained on exit.
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0, 1); step(1, 0, 0, 0);
    end
    snap = n_kind[3];
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    chk("drain_count", n_kind[3] - snap, 7);
    chk("drain_done_editing", editing, 0);

    // Idle timeout into lock; presses ignored; ticks still deferred.
    for (int k = 0; k < 53; k++) step(1, 0, 0, 0);
    chk("lock_field_sel", field_sel, 3);
    chk("lock_editing", editing, 1);
    step(1, 1, 0, 0); step(1, 0, 1, 1); step(1, 0, 0, 0); step(1, 0, 1, 0); step(1, 0, 1, 1);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);

    // Field and inc rising together: field wins.
    step(1, 0, 0, 0); step(1, 1, 1, 0); step(1, 0, 0, 0);
    chk("collide_field", field_sel, 1);
    // Tick on the cycle an inc strobe appears is deferred.
    step(1, 0, 1, 0); step(1, 0, 1, 1); step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);

    // Reset while editing month with three pending ticks.
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1);
    chk("pre_reset_month", field_sel, 1);
    do_reset();
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);

    // Randomised traffic.
    re = 1; rf = 0; ri = 0; rn = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 39) == 0) re = !re;
      rf = ((k % 400) < 250) && ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, ri ? 15 : 7) == 0) ri = !ri;
      rn = ($urandom_range(0, 5) == 0);
      step(re, rf, ri, rn);
    end
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("events_left", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calendar_edit_ctrl.md
Name: calendar_edit_ctrl

Overview:
Controller that sequences the calendar datapath (day/month/year counters) between run mode and user edit mode. It turns switch/button inputs into 1-cycle field increment strobes with auto-repeat, and selects and blinks the edited field. It also arbitrates the new_day tick against user edits, deferring ticks while editing. It sits between the debounced button/switch logic and the calendar counter block, and drives the display mux selects.

Parameters:
HOLD_DLY, 16'd500, cycles inc_btn must stay high before auto-repeat starts
RPT_PER, 16'd100, cycles between auto-repeat strobes
TIMEOUT, 24'd5000, idle cycles in edit before forced exit to EDIT_LOCK
PEND_MAX, 3'd7, saturation value of the deferred new_day counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
edit_en  in  1  edit switch level, synchronous to clk
field_btn  in  1  debounced field-select button level
inc_btn  in  1  debounced increment button level
new_day  in  1  1-cycle day tick from timekeeping
inc_day  out  1  1-cycle strobe: increment day field
inc_month  out  1  1-cycle strobe: increment month field
inc_year  out  1  1-cycle strobe: increment year field
adv_day  out  1  1-cycle strobe: calendar day advance (rollover path)
field_sel  out  2  00 day, 01 month, 10 year, 11 none
blink  out  4  digit blink mask
show_year  out  1  display mux: 1 = year digits, 0 = day/month
editing  out  1  high in any EDIT_* state

Behaviour:
- Reset (async): state RUN; all strobes 0; field_sel 11; blink 0000; show_year 0; pending 0; timers 0.
- Edge detect: field_btn and inc_btn registered; rise = cur & ~prev. One cycle of detection latency.
- States: RUN, EDIT_DAY, EDIT_MONTH, EDIT_YEAR, EDIT_LOCK, DRAIN.
- RUN: edit_en=1 -> EDIT_DAY. inc_btn rise toggles show_year. new_day -> adv_day in the same cycle (combinational pass-through, registered enable).
- EDIT_*: field_btn rise rotates DAY->MONTH->YEAR->DAY. field_sel = 00/01/10. blink = 1100/0011/1111. show_year = 1 in EDIT_YEAR, 0 otherwise.
- Increment: inc_btn rise -> one strobe on the current field the next cycle. Held: repeat strobe once the hold counter reaches HOLD_DLY, then every RPT_PER cycles. The hold counter clears on release or on a field change.
- A field change and an inc rise in the same cycle: the field change wins. The inc is dropped and the hold counter clears.
- Timeout: the idle counter counts in EDIT_* and clears on any button rise or repeat strobe. Reaching TIMEOUT -> EDIT_LOCK.
- EDIT_LOCK: field_sel 11, blink 0000, no strobes. Waits for edit_en=0, then -> DRAIN.
- edit_en=0 in any EDIT_* state -> DRAIN (same cycle decision, takes effect next cycle).
- new_day while in EDIT_*/EDIT_LOCK: pending += 1, saturating at PEND_MAX. adv_day stays 0.
- DRAIN: one adv_day per cycle while pending>0, decrementing each cycle. Goes to RUN when pending=0.
  - new_day arriving in DRAIN increments pending (net 0 that cycle if both occur).
  - edit_en=1 in DRAIN returns to EDIT_DAY; pending is preserved.
- Mutual exclusion: at most one of inc_day/inc_month/inc_year/adv_day is high in any cycle.
- Counter widths: hold/repeat counter 16 bits, idle counter 24 bits. Counters saturate and never wrap.

Decomposition:
- Package calendar_pkg: state enum, field_sel encodings (FLD_DAY/FLD_MONTH/FLD_YEAR/FLD_NONE), blink mask constants.
- One sub-module: btn_repeat (edge detect + HOLD_DLY/RPT_PER auto-repeat, outputs a 1-cycle fire). Instantiated once for inc_btn.

Test Plan:
- Reset mid-edit: assert rst in EDIT_MONTH with pending=3 -> next edge: RUN, field_sel=11, blink=0000, pending=0, no adv_day.
- Field rotation: edit_en=1, then 3 field_btn presses -> field_sel 00->01->10->00, blink 1100->0011->1111->1100.
- Auto-repeat: HOLD_DLY=10, RPT_PER=4, inc_btn held 30 cycles in EDIT_DAY -> inc_day at press+1, then at hold 10, 14, 18, 22, 26, 30 (7 strobes).
- Deferred days: 9 new_day pulses during edit, then edit_en=0 -> exactly 7 consecutive adv_day strobes in DRAIN, then RUN.
- Timeout: TIMEOUT=50, no buttons after entering edit -> EDIT_LOCK at cycle 50. Presses are ignored. edit_en=0 -> DRAIN -> RUN.
- Collision: field_btn and inc_btn rise together in EDIT_DAY -> field_sel=01, no inc strobe.
- Collision: new_day on a cycle where an inc strobe fires -> no adv_day, pending=1.
